lsu_amo: RTL

Load/store/atomic sequencer between the core's memory-stage request and the data port of the unified 1 MiB RAM. Accepts one request at a time via valid/ready, drives the RAM's combinational-read / clocked-write data port (addr, data, memo, mask), performs byte extraction and sign/zero extension for loads, and runs read-modify-write sequences for RV64A AMOs. It also implements the LR/SC reservation and returns results or exceptions on a valid/ready response channel.

---
 rtl/lsu_amo.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_amo.sv
// Load/store/atomic sequencer between the memory-stage request and the RAM data port.
// Handles byte extraction and extension, AMO read-modify-write and the LR/SC reservation.
module lsu_amo (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic [1:0]  rsp_exc,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_data,
    output logic [1:0]  mem_memo,
    output logic [7:0]  mem_mask,
    input  logic [63:0] mem_resp,
    input  logic        mem_exc,
    output logic [1:0]  dbg_state
);

    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LR    = 4'd2;
    localparam logic [3:0] OP_SC    = 4'd3;
    localparam logic [3:0] OP_SWAP  = 4'd4;
    localparam logic [3:0] OP_ADD   = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_AND   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_MIN   = 4'd9;
    localparam logic [3:0] OP_MAX   = 4'd10;
    localparam logic [3:0] OP_MINU  = 4'd11;
    localparam logic [3:0] OP_MAXU  = 4'd12;

    localparam logic [1:0] EXC_NONE  = 2'd0;
    localparam logic [1:0] EXC_ALIGN = 2'd1;
    localparam logic [1:0] EXC_FAULT = 2'd2;
    localparam logic [1:0] EXC_ILL   = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_WR, S_RESP} state_t;

    state_t      state_q;
    logic [3:0]  op_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] old_q;
    logic [63:0] rsp_data_q;
    logic [1:0]  rsp_exc_q;
    logic        resv_valid_q;
    logic [63:0] resv_addr_q;
    logic [1:0]  resv_size_q;

    function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] size,
                                           input logic sgn);
        case (size)
            2'd0:    extend = {{56{sgn & d[7]}}, d[7:0]};
            2'd1:    extend = {{48{sgn & d[15]}}, d[15:0]};
            2'd2:    extend = {{32{sgn & d[31]}}, d[31:0]};
            default: extend = d;
        endcase
    endfunction

    // Word operands are widened first so a single 64-bit compare serves both widths.
    function automatic logic [63:0] amo_calc(input logic [3:0] op, input logic is_w,
                                             input logic [63:0] a, input logic [63:0] b);
        logic [63:0] sa, sb, za, zb, r;
        sa = is_w ? {{32{a[31]}}, a[31:0]} : a;
        sb = is_w ? {{32{b[31]}}, b[31:0]} : b;
        za = is_w ? {32'd0, a[31:0]} : a;
        zb = is_w ? {32'd0, b[31:0]} : b;
        case (op)
            OP_ADD:  r = a + b;
            OP_XOR:  r = a ^ b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_MIN:  r = ($signed(sa) < $signed(sb)) ? a : b;
            OP_MAX:  r = ($signed(sa) > $signed(sb)) ? a : b;
            OP_MINU: r = (za < zb) ? a : b;
            OP_MAXU: r = (za > zb) ? a : b;
            default: r = b;
        endcase
        amo_calc = r;
    endfunction

    logic [7:0]  size_mask;
    logic [63:0] load_val;
    logic [63:0] amo_val;
    logic        sc_hit;
    logic        resv_clash;
    logic        req_amo_like;
    logic        req_misaligned;

    always_comb begin
        case (size_q)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    assign load_val       = extend(mem_resp, size_q, !(op_q == OP_LOAD && uns_q));
    assign amo_val        = amo_calc(op_q, (size_q == 2'd2), old_q, wdata_q);
    assign sc_hit         = resv_valid_q && (addr_q == resv_addr_q) && (size_q == resv_size_q);
    assign resv_clash     = resv_valid_q && (addr_q[63:3] == resv_addr_q[63:3]);
    assign req_amo_like   = (req_op >= OP_LR);
    assign req_misaligned = req_size[0] ? (req_addr[2:0] != 3'd0) : (req_addr[1:0] != 2'd0);

    always_comb begin
        mem_addr = 64'd0;
        mem_data = 64'd0;
        mem_memo = 2'b00;
        mem_mask = 8'h00;
        case (state_q)
            S_ACC: begin
                mem_addr = addr_q;
                if (!mem_exc && (op_q == OP_STORE || (op_q == OP_SC && sc_hit))) begin
                    mem_memo = 2'b01;
                    mem_mask = size_mask;
                    mem_data = wdata_q;
                end
            end
            S_WR: begin
                mem_addr = addr_q;
                mem_memo = 2'b01;
                mem_mask = size_mask;
                mem_data = amo_val;
            end
            default: ;
        endcase
        // No write may reach the RAM while reset is held, even mid-sequence.
        if (!reset) mem_memo = 2'b00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            op_q         <= 4'd0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            addr_q       <= 64'd0;
            wdata_q      <= 64'd0;
            old_q        <= 64'd0;
            rsp_data_q   <= 64'd0;
            rsp_exc_q    <= EXC_NONE;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= 64'd0;
            resv_size_q  <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q       <= req_op;
                        size_q     <= req_size;
                        uns_q      <= req_unsigned;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        rsp_data_q <= 64'd0;
                        rsp_exc_q  <= EXC_NONE;
                        if (req_op > OP_MAXU) begin
                            rsp_exc_q <= EXC_ILL;
                            state_q   <= S_RESP;
                        end else if (req_amo_like && !req_size[1]) begin
                            rsp_exc_q <= EXC_ILL;
                            state_q   <= S_RESP;
                            if (req_op == OP_SC) resv_valid_q <= 1'b0;
                        end else if (req_amo_like && req_misaligned) begin
                            rsp_exc_q <= EXC_ALIGN;
                            state_q   <= S_RESP;
                            if (req_op == OP_SC) resv_valid_q <= 1'b0;
                        end else begin
                            state_q <= S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    if (mem_exc) begin
                        rsp_exc_q  <= EXC_FAULT;
                        rsp_data_q <= 64'd0;
                        state_q    <= S_RESP;
                    end else begin
                        case (op_q)
                            OP_LOAD: begin
                                rsp_data_q <= load_val;
                                state_q    <= S_RESP;
                            end
                            OP_LR: begin
                                rsp_data_q   <= load_val;
                                resv_valid_q <= 1'b1;
                                resv_addr_q  <= addr_q;
                                resv_size_q  <= size_q;
                                state_q      <= S_RESP;
                            end
                            OP_STORE: begin
                                if (resv_clash) resv_valid_q <= 1'b0;
                                state_q <= S_RESP;
                            end
                            OP_SC: begin
                                rsp_data_q   <= {63'd0, !sc_hit};
                                resv_valid_q <= 1'b0;
                                state_q      <= S_RESP;
                            end
                            default: begin
                                old_q      <= load_val;
                                rsp_data_q <= load_val;
                                state_q    <= S_WR;
                            end
                        endcase
                    end
                end
                S_WR: begin
                    if (resv_clash) resv_valid_q <= 1'b0;
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_exc   = rsp_exc_q;
    assign dbg_state = state_q;

endmodule
